// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
//
// Memory-side responder for a 6502-style processor bus. Decodes every bus
// cycle into one of three regions and answers it:
//   RAM  : 0x0000 .. 2^RAM_AW-1, read/write, optional wait states
//   VEC  : 0xFFFA .. 0xFFFF, read-only NMI/RESET/IRQ vector bytes
//   other: unmapped; reads return 0xFF, writes are dropped, and either one
//          raises UNMAPPED for the cycle that follows
//
// Every PHI_0 cycle in which RDY is high is one complete bus cycle; there is
// no separate request strobe.
//
// Configuration macro:
//   WAIT_STATE_EN  defined   -> RAM accesses take WAIT_CYCLES wait states,
//                               sequenced by a two-state FSM (IDLE/WAIT) and a
//                               4-bit down-counter.
//                  undefined -> no FSM or counter, RDY tied high, every access
//                               is zero-wait and WAIT_CYCLES is ignored.
//
// Parameters:
//   RAM_AW       RAM address width (8..14)
//   WAIT_CYCLES  RAM wait states per access (0..15)
//   NMI_VEC / RESET_VEC / IRQ_VEC  16-bit vector contents (lo byte at even
//                address, hi byte at odd address)
//
// Ports:
//   PHI_0     in   clock, all state changes on its rising edge
//   RES       in   asynchronous active-high reset
//   AB        in   [15:0] processor address
//   RW        in   1 = read, 0 = write
//   DB_OUT    in   [7:0] processor write data
//   DB_IN     out  [7:0] registered read data, held until the next read
//   RDY       out  1 = current bus cycle completes at the next rising edge
//   UNMAPPED  out  registered one-cycle pulse after an unmapped access
// -----------------------------------------------------------------------------
module bus_responder #(
    parameter int          RAM_AW      = 10,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] NMI_VEC     = 16'hFFF0,
    parameter logic [15:0] RESET_VEC   = 16'h0200,
    parameter logic [15:0] IRQ_VEC     = 16'hFFF0
) (
    input  logic        PHI_0,
    input  logic        RES,
    input  logic [15:0] AB,
    input  logic        RW,
    input  logic [7:0]  DB_OUT,
    output logic [7:0]  DB_IN,
    output logic        RDY,
    output logic        UNMAPPED
);

    localparam int RAM_DEPTH = 1 << RAM_AW;

    // Vector byte lookup; AB[2:0] selects which byte of which vector.
    function automatic logic [7:0] vec_byte(input logic [2:0] sel);
        case (sel)
            3'd2:    return NMI_VEC[7:0];
            3'd3:    return NMI_VEC[15:8];
            3'd4:    return RESET_VEC[7:0];
            3'd5:    return RESET_VEC[15:8];
            3'd6:    return IRQ_VEC[7:0];
            3'd7:    return IRQ_VEC[15:8];
            default: return 8'hFF;
        endcase
    endfunction

    // ---------------------------------------------------------------- decode
    logic              ram_hit;
    logic              vec_hit;
    logic              unmap_hit;
    logic [RAM_AW-1:0] ram_addr;

    assign ram_hit   = (AB >> RAM_AW) == 16'd0;
    // 0xFFF8/0xFFF9 share the top 13 bits with the vectors but are unmapped.
    assign vec_hit   = (AB[15:3] == 13'h1FFF) && (AB[2:1] != 2'b00);
    assign unmap_hit = !ram_hit && !vec_hit;
    assign ram_addr  = AB[RAM_AW-1:0];

    // ---------------------------------------------------------- wait control
`ifdef WAIT_STATE_EN
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt;
    logic [3:0] cnt_nxt;
    logic       rdy_fsm;

    always_ff @(posedge PHI_0 or posedge RES) begin
        if (RES) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // RDY drops in the very cycle a RAM access is first seen, so the
    // processor holds the bus from the start; the access completes in the
    // WAIT cycle where the counter has reached zero.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rdy_fsm   = 1'b1;
        case (state)
            IDLE: begin
                if (ram_hit && HAS_WAIT) begin
                    rdy_fsm   = 1'b0;
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_LOAD;
                end
            end
            WAIT: begin
                if (cnt != 4'd0) begin
                    rdy_fsm = 1'b0;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Reset forces RDY high so a held processor is released immediately.
    assign RDY = RES | rdy_fsm;
`else
    logic unused_wait_cfg;
    assign unused_wait_cfg = (WAIT_CYCLES > 15);
    assign RDY = 1'b1;
`endif

    // An access is committed only at a completing edge outside reset.
    logic commit;
    assign commit = RDY && !RES;

    // ------------------------------------------------------------ RAM array
    // Contents survive reset; only the write is gated off while RES is high.
    logic [7:0] mem [RAM_DEPTH];

    always_ff @(posedge PHI_0) begin
        if (commit && ram_hit && !RW) begin
            mem[ram_addr] <= DB_OUT;
        end
    end

    // ------------------------------------------------------ read data / flag
    always_ff @(posedge PHI_0 or posedge RES) begin
        if (RES) begin
            DB_IN    <= 8'h00;
            UNMAPPED <= 1'b0;
        end else begin
            UNMAPPED <= commit && unmap_hit;
            if (commit && RW) begin
                if (ram_hit) begin
                    DB_IN <= mem[ram_addr];
                end else if (vec_hit) begin
                    DB_IN <= vec_byte(AB[2:0]);
                end else begin
                    DB_IN <= 8'hFF;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
//
// Directed bench for bus_responder with WAIT_CYCLES=2 and default vectors.
// Expected RDY-low counts follow the build: 2 per RAM access when
// WAIT_STATE_EN is defined, 0 otherwise.
// -----------------------------------------------------------------------------
module tb_bus_responder;

    localparam int RAM_AW = 10;
`ifdef WAIT_STATE_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    logic        PHI_0;
    logic        RES;
    logic [15:0] AB;
    logic        RW;
    logic [7:0]  DB_OUT;
    logic [7:0]  DB_IN;
    logic        RDY;
    logic        UNMAPPED;

    int n_chk  = 0;
    int n_pass = 0;

    bus_responder #(
        .RAM_AW      (RAM_AW),
        .WAIT_CYCLES (2),
        .NMI_VEC     (16'hFFF0),
        .RESET_VEC   (16'h0200),
        .IRQ_VEC     (16'hFFF0)
    ) dut (
        .PHI_0    (PHI_0),
        .RES      (RES),
        .AB       (AB),
        .RW       (RW),
        .DB_OUT   (DB_OUT),
        .DB_IN    (DB_IN),
        .RDY      (RDY),
        .UNMAPPED (UNMAPPED)
    );

    initial PHI_0 = 1'b0;
    always #5 PHI_0 = ~PHI_0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive at the falling edge, hold while RDY is low, and
    // return 1 ns after the completing rising edge. lows = wait cycles seen.
    task automatic access(input logic [15:0] a, input logic rw,
                          input logic [7:0] d, output int lows);
        @(negedge PHI_0);
        AB     = a;
        RW     = rw;
        DB_OUT = d;
        lows   = 0;
        #1;
        while (!RDY && lows < 32) begin
            lows++;
            @(negedge PHI_0);
            #1;
        end
        if (lows >= 32) begin
            check_val("rdy_timeout", 32'(lows), 32'(EXP_WAIT));
        end
        @(posedge PHI_0);
        #1;
    endtask

    task automatic do_read(input string tag, input logic [15:0] a,
                           input int exp_wait, input logic [7:0] exp_data,
                           input logic exp_unm);
        int lows;
        access(a, 1'b1, 8'h00, lows);
        check_val({tag, "_wait"}, 32'(lows), 32'(exp_wait));
        check_val({tag, "_data"}, 32'(DB_IN), 32'(exp_data));
        check_val({tag, "_unm"},  32'(UNMAPPED), 32'(exp_unm));
    endtask

    task automatic do_write(input string tag, input logic [15:0] a,
                            input logic [7:0] d, input int exp_wait,
                            input logic exp_unm);
        int lows;
        access(a, 1'b0, d, lows);
        check_val({tag, "_wait"}, 32'(lows), 32'(exp_wait));
        check_val({tag, "_unm"},  32'(UNMAPPED), 32'(exp_unm));
    endtask

    initial begin
        RES    = 1'b1;
        AB     = 16'hFFFC;
        RW     = 1'b1;
        DB_OUT = 8'h00;

        repeat (3) @(posedge PHI_0);
        #1;
        check_val("rst_db_in", 32'(DB_IN), 32'h00);
        check_val("rst_unm",   32'(UNMAPPED), 32'h0);
        check_val("rst_rdy",   32'(RDY), 32'h1);

        @(negedge PHI_0);
        RES = 1'b0;

        // RAM write then read back
        do_write("wr_0010", 16'h0010, 8'hA5, EXP_WAIT, 1'b0);
        do_read ("rd_0010", 16'h0010, EXP_WAIT, 8'hA5, 1'b0);

        // vectors, including the ignored write
        do_read ("rd_fffc", 16'hFFFC, 0, 8'h00, 1'b0);
        do_read ("rd_fffd", 16'hFFFD, 0, 8'h02, 1'b0);
        do_write("wr_fffc", 16'hFFFC, 8'h55, 0, 1'b0);
        check_val("wr_fffc_hold", 32'(DB_IN), 32'h02);
        do_read ("rd_fffc2", 16'hFFFC, 0, 8'h00, 1'b0);
        do_read ("rd_fffa", 16'hFFFA, 0, 8'hF0, 1'b0);
        do_read ("rd_fffb", 16'hFFFB, 0, 8'hFF, 1'b0);
        do_read ("rd_fffe", 16'hFFFE, 0, 8'hF0, 1'b0);
        do_read ("rd_ffff", 16'hFFFF, 0, 8'hFF, 1'b0);

        // unmapped read/write; pulse must drop after one cycle
        do_write("wr_0000", 16'h0000, 8'h11, EXP_WAIT, 1'b0);
        do_read ("rd_8000", 16'h8000, 0, 8'hFF, 1'b1);
        do_read ("rd_fffd2", 16'hFFFD, 0, 8'h02, 1'b0);
        do_write("wr_8000", 16'h8000, 8'h12, 0, 1'b1);
        check_val("wr_8000_hold", 32'(DB_IN), 32'h02);
        do_read ("rd_0000", 16'h0000, EXP_WAIT, 8'h11, 1'b0);

        // RAM boundary and neighbouring unmapped addresses
        do_write("wr_03ff", 16'h03FF, 8'h7E, EXP_WAIT, 1'b0);
        do_read ("rd_03ff", 16'h03FF, EXP_WAIT, 8'h7E, 1'b0);
        do_read ("rd_0400", 16'h0400, 0, 8'hFF, 1'b1);
        do_read ("rd_fff9", 16'hFFF9, 0, 8'hFF, 1'b1);

        // back-to-back RAM writes then reads
        do_write("wr_0100", 16'h0100, 8'h81, EXP_WAIT, 1'b0);
        do_write("wr_0101", 16'h0101, 8'h42, EXP_WAIT, 1'b0);
        do_read ("rd_0100", 16'h0100, EXP_WAIT, 8'h81, 1'b0);
        do_read ("rd_0101", 16'h0101, EXP_WAIT, 8'h42, 1'b0);

        // reset in the middle of a write to 0x0020
        do_write("wr_0020", 16'h0020, 8'h11, EXP_WAIT, 1'b0);
        do_read ("rd_0020", 16'h0020, EXP_WAIT, 8'h11, 1'b0);
        @(negedge PHI_0);
        AB     = 16'h0020;
        RW     = 1'b0;
        DB_OUT = 8'h3C;
`ifdef WAIT_STATE_EN
        @(posedge PHI_0);
        #1;
        check_val("mid_wait_rdy", 32'(RDY), 32'h0);
`endif
        #2;
        RES = 1'b1;
        #1;
        check_val("res_rdy",   32'(RDY), 32'h1);
        check_val("res_db_in", 32'(DB_IN), 32'h00);
        check_val("res_unm",   32'(UNMAPPED), 32'h0);
        @(posedge PHI_0);
        #1;
        check_val("res_db_in2", 32'(DB_IN), 32'h00);
        @(negedge PHI_0);
        RW  = 1'b1;
        RES = 1'b0;
        do_read("rd_0020_old", 16'h0020, EXP_WAIT, 8'h11, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
